// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative HI/LO multiply/divide unit.
package muldiv_pkg;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_DIVU  = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_seq_if.sv
// Request/result bundle between the execute stage and the multiply/divide unit.
interface muldiv_seq_if #(
  parameter int unsigned WIDE = 32
);

  logic            start;
  logic [1:0]      op;
  logic [WIDE-1:0] a;
  logic [WIDE-1:0] b;
  logic            busy;
  logic            done;
  logic [WIDE-1:0] hi;
  logic [WIDE-1:0] lo;
  logic            dbz;

  modport master (
    output start, op, a, b,
    input  busy, done, hi, lo, dbz
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hi, lo, dbz
  );

endinterface

// File: rtl/muldiv_seq.sv
// One-bit-per-cycle MULTU / DIVU unit producing HI/LO; results hold until the next completion.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDE = 32
) (
  input  logic         clk,
  input  logic         rst,
  muldiv_seq_if.slave  bus
);

  localparam int unsigned CW = $clog2(WIDE);
  localparam int unsigned AW = 2 * WIDE;

  state_e          state, state_nx;
  logic            load, step;
  logic [CW-1:0]   cnt;
  logic            is_div;
  logic [WIDE-1:0] opnd;
  logic [AW-1:0]   acc, acc_nx;
  logic [WIDE:0]   mul_sum, div_shift, div_trial;

  logic            busy_q, done_q, dbz_q;
  logic [WIDE-1:0] hi_q, lo_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state and datapath enables
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    step     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start && (bus.op == OP_MULTU || bus.op == OP_DIVU)) begin
          load     = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == '0) state_nx = FIN;
      end
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // One iteration: shift-add for MULTU, restoring subtract for DIVU.
  // Both leave {remainder/upper, quotient/lower} in acc, so HI/LO map identically.
  always_comb begin
    mul_sum   = {1'b0, acc[AW-1:WIDE]} + {1'b0, (acc[0] ? opnd : {WIDE{1'b0}})};
    div_shift = acc[AW-1:WIDE-1];
    div_trial = div_shift - {1'b0, opnd};
    if (is_div) begin
      if (div_trial[WIDE]) acc_nx = {div_shift[WIDE-1:0], acc[WIDE-2:0], 1'b0};
      else                 acc_nx = {div_trial[WIDE-1:0], acc[WIDE-2:0], 1'b1};
    end else begin
      acc_nx = {mul_sum, acc[WIDE-1:1]};
    end
  end

  // Operand latch, accumulator and iteration counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      is_div <= 1'b0;
      opnd   <= '0;
      acc    <= '0;
    end else if (load) begin
      cnt    <= CW'(WIDE - 1);
      is_div <= (bus.op == OP_DIVU);
      // MULTU adds a into the upper half while b shifts out; DIVU shifts a in against divisor b.
      opnd   <= (bus.op == OP_DIVU) ? bus.b : bus.a;
      acc    <= {{WIDE{1'b0}}, ((bus.op == OP_DIVU) ? bus.a : bus.b)};
    end else if (step) begin
      cnt    <= cnt - CW'(1);
      acc    <= acc_nx;
    end
  end

  // Registered status and result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      dbz_q  <= 1'b0;
    end else begin
      busy_q <= (state_nx == RUN);
      done_q <= (state_nx == FIN);
      if (step && cnt == '0) begin
        hi_q  <= acc_nx[AW-1:WIDE];
        lo_q  <= acc_nx[WIDE-1:0];
        dbz_q <= is_div && (opnd == '0);
      end
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.dbz  = dbz_q;

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative multiply/divide unit for the MIPS core. It replaces the single-cycle combinational multiplier feeding the HI/LO registers. It accepts a MULTU or DIVU request from the execute stage, computes one bit per cycle, and produces the 2×WIDE-bit result as separate HI/LO words. Those words are read by MFHI/MFLO. Control logic stalls the pipeline while `busy` is high.

## Interface
- `WIDE`, default 32: operand and HI/LO width.
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: reset; asynchronous, active-high.
- `start` in 1: request strobe; sampled only in IDLE.
- `op` in 2: 00 = MULTU, 01 = DIVU, 1x = reserved.
- `a` in WIDE: multiplicand / dividend.
- `b` in WIDE: multiplier / divisor.
- `busy` out 1: iteration in progress.
- `done` out 1: one-cycle pulse; `hi`/`lo` hold the new result.
- `hi` out WIDE: MULTU = product[2·WIDE-1:WIDE]; DIVU = remainder.
- `lo` out WIDE: MULTU = product[WIDE-1:0]; DIVU = quotient.
- `dbz` out 1: divide-by-zero flag; valid with `done`, held until the next `done`.

## Operation
- States:
  - **IDLE**: wait for `start`.
  - **RUN**: iterate, with a counter running from WIDE-1 down to 0.
  - **FIN**: signal completion.
- Transitions:
  - IDLE→RUN on `start` with `op` = 00 or 01. The edge latches `a`, `b`, `op` into internal registers and sets count = WIDE-1.
  - RUN→RUN while count ≠ 0; each edge does one iteration and decrements count.
  - RUN→FIN on the edge where count = 0. That edge performs the final iteration and writes `hi`, `lo`, `dbz`.
  - FIN→IDLE unconditionally.
- `start` in RUN or FIN: ignored, no queuing.
- `start` with `op` = 1x: ignored; the unit stays in IDLE and `busy`/`done` stay low.
- Inputs `a`, `b`, `op` are don't-care after the accepting edge; the latched copies are used.
- MULTU is an unsigned shift-add over a 2·WIDE accumulator. Result: {hi, lo} = a·b exactly, with no truncation.
- DIVU is an unsigned restoring divide with a WIDE+1-bit partial remainder. Result: lo = a / b, hi = a mod b.
- DIVU with b = 0 follows the natural result of the algorithm: lo = all ones, hi = a, dbz = 1.
- `dbz` is 0 for every MULTU and for DIVU with b ≠ 0.
- `hi`, `lo` and `dbz` change only on the RUN→FIN edge. Otherwise they hold their last value, so MFHI/MFLO remain valid indefinitely.
- Reset values: state IDLE, `busy` 0, `done` 0, `hi` 0, `lo` 0, `dbz` 0; internal registers 0.
- Reset mid-operation: the unit aborts immediately to reset values, no `done` pulse is produced, and the partial result is discarded.

## Timing
- Call the cycle in which `start` is sampled in IDLE cycle 0.
- `busy` = (state == RUN), a registered state decode. It is high in cycles 1..WIDE (1..32 for the default).
- `done` = (state == FIN). It is high only in cycle WIDE+1 (33), with `hi`/`lo`/`dbz` already updated in that cycle.
- Cycle WIDE+2 is IDLE, so the earliest next `start` is sampled in cycle WIDE+2.
- Back-to-back throughput: one operation per WIDE+2 cycles.
- No combinational path from inputs to outputs.

## Structure
- Shared package `muldiv_pkg` holds:
  - the `op` encodings: OP_MULTU = 2'b00, OP_DIVU = 2'b01;
  - the state encodings: IDLE, RUN, FIN.
- Flat implementation. There is no natural sub-module, because the datapath is one accumulator/remainder register plus a shared subtract/add.
- The iteration counter is $clog2(WIDE) bits wide.

## Test plan
All scenarios use WIDE = 32.
1. Assert `rst` → `busy` = 0, `done` = 0, `hi` = 0, `lo` = 0, `dbz` = 0. Hold `start` = 1 during `rst` → no response.
2. MULTU with a = 0xFFFFFFFF, b = 0xFFFFFFFF in cycle 0 → `busy` high in cycles 1..32; `done` in cycle 33 with hi = 0xFFFFFFFE, lo = 0x00000001.
3. DIVU with a = 100, b = 7 → `done` in cycle 33 with lo = 14, hi = 2, dbz = 0. Then DIVU 7/100 → lo = 0, hi = 7.
4. DIVU with a = 5, b = 0 → lo = 0xFFFFFFFF, hi = 5, dbz = 1. A following MULTU 3·4 → hi = 0, lo = 12, dbz = 0.
5. Start MULTU 6·7, then change `a`/`b` and pulse `start` in cycle 10 → the second request is ignored; a single `done` in cycle 33 with lo = 42. Also start with `op` = 2'b10 → `busy` stays 0.
6. Assert `rst` in cycle 10 of a DIVU → `busy` drops immediately, `hi`/`lo` = 0, and no `done` occurs in cycle 33.
